// File: rtl/rf_wb_arbiter_pkg.sv
// rtl/rf_wb_arbiter_pkg.sv - shared widths, constants and requester indices for the write-back arbiter
package rf_wb_arbiter_pkg;

    localparam int RegAddrBus = 5;
    localparam int RegDataBus = 32;

    localparam logic [RegAddrBus-1:0] ZeroReg  = 5'd0;
    localparam logic [RegDataBus-1:0] ZeroWord = 32'd0;

    localparam int WB_REQ_ALU = 0;
    localparam int WB_REQ_LSU = 1;
    localparam int WB_REQ_MDU = 2;
    localparam int WB_REQ_NUM = 3;

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// rtl/rf_wb_arbiter_rr_arbiter.sv - round-robin grant with a rotating start pointer
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  i_req,
    input  logic          i_en,
    input  logic          i_accept,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_grant_idx
);

    logic [IW-1:0] r_ptr;

    // Scan from r_ptr upward with wraparound; the first requester found wins.
    always_comb begin
        int  k;
        logic found;
        o_grant     = '0;
        o_grant_idx = '0;
        found       = 1'b0;
        k           = 0;
        for (int off = 0; off < N; off++) begin
            k = int'(r_ptr) + off;
            if (k >= N) k = k - N;
            if (i_en && !found && i_req[IW'(k)]) begin
                found               = 1'b1;
                o_grant[IW'(k)]     = 1'b1;
                o_grant_idx         = IW'(k);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_accept) begin
            r_ptr <= (o_grant_idx == IW'(N-1)) ? '0 : o_grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - round-robin sharing of the regfile write port, registered output
// Optional contention counter enabled by WB_ARB_STAT_EN.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int N_REQ  = WB_REQ_NUM,
    parameter int ADDR_W = RegAddrBus,
    parameter int DATA_W = RegDataBus
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    I_stall,
    input  logic [N_REQ-1:0]        I_req_valid,
    input  logic [N_REQ*ADDR_W-1:0] I_req_waddr,
    input  logic [N_REQ*DATA_W-1:0] I_req_wdata,
    output logic [N_REQ-1:0]        O_req_ready,
    output logic                    O_rd_we,
    output logic [ADDR_W-1:0]       O_rd_waddr,
    output logic [DATA_W-1:0]       O_rd_wdata,
    output logic                    O_busy,
    output logic [31:0]             O_conflict_cnt
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]  w_grant;
    logic [IW-1:0]     w_grant_idx;
    logic              w_handshake;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;

    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_wdata;

    // Gating with rst keeps every ready low while reset is held.
    rr_arbiter #(.N(N_REQ), .IW(IW)) u_rr (
        .clk         (clk),
        .rst         (rst),
        .i_req       (I_req_valid),
        .i_en        (~I_stall & ~rst),
        .i_accept    (w_handshake),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    assign O_req_ready = w_grant;
    assign w_handshake = |(I_req_valid & w_grant);
    assign w_waddr     = I_req_waddr[w_grant_idx*ADDR_W +: ADDR_W];
    assign w_wdata     = I_req_wdata[w_grant_idx*DATA_W +: DATA_W];
    assign O_busy      = (|I_req_valid) & ~(|w_grant);

    // x0 writes drain the requester but never assert the regfile write enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else if (w_handshake) begin
            r_we    <= (w_waddr != '0);
            r_waddr <= w_waddr;
            r_wdata <= w_wdata;
        end else begin
            r_we    <= 1'b0;
        end
    end

    assign O_rd_we    = r_we;
    assign O_rd_waddr = r_waddr;
    assign O_rd_wdata = r_wdata;

`ifdef WB_ARB_STAT_EN
    logic [31:0] r_conflict_cnt;
    logic        w_multi;

    assign w_multi = ($countones(I_req_valid) >= 2);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_conflict_cnt <= '0;
        end else if (!I_stall && w_multi && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
            r_conflict_cnt <= r_conflict_cnt + 32'd1;
        end
    end

    assign O_conflict_cnt = r_conflict_cnt;
`else
    assign O_conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed vector bench for rf_wb_arbiter
module tb_rf_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        I_stall;
    logic [2:0]  I_req_valid;
    logic [14:0] I_req_waddr;
    logic [95:0] I_req_wdata;
    logic [2:0]  O_req_ready;
    logic        O_rd_we;
    logic [4:0]  O_rd_waddr;
    logic [31:0] O_rd_wdata;
    logic        O_busy;
    logic [31:0] O_conflict_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter dut (
        .clk            (clk),
        .rst            (rst),
        .I_stall        (I_stall),
        .I_req_valid    (I_req_valid),
        .I_req_waddr    (I_req_waddr),
        .I_req_wdata    (I_req_wdata),
        .O_req_ready    (O_req_ready),
        .O_rd_we        (O_rd_we),
        .O_rd_waddr     (O_rd_waddr),
        .O_rd_wdata     (O_rd_wdata),
        .O_busy         (O_busy),
        .O_conflict_cnt (O_conflict_cnt)
    );

    typedef struct {
        logic        stall;
        logic [2:0]  valid;
        logic [14:0] waddr;
        logic [95:0] wdata;
        logic [2:0]  ready;
        logic        busy;
        logic        we;
        logic [4:0]  oaddr;
        logic [31:0] odata;
    } vec_t;

    localparam int NV = 22;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic s, input logic [2:0] v, input logic [14:0] a,
                                input logic [95:0] d, input logic [2:0] r, input logic b,
                                input logic we, input logic [4:0] oa, input logic [31:0] od);
        vec_t t;
        t.stall = s; t.valid = v; t.waddr = a; t.wdata = d;
        t.ready = r; t.busy = b; t.we = we; t.oaddr = oa; t.odata = od;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    localparam logic [14:0] A_ALL  = {5'd3, 5'd2, 5'd1};
    localparam logic [95:0] D_ALL  = {32'hC, 32'hB, 32'hA};
    localparam logic [14:0] A_STL  = {5'd3, 5'd0, 5'd0};
    localparam logic [95:0] D_STL  = {32'hC, 32'h0, 32'h0};
    localparam logic [14:0] A_PAIR = {5'd9, 5'd0, 5'd7};
    localparam logic [95:0] D_PAIR = {32'h99, 32'h0, 32'h77};

    initial begin
        int exp_cnt;

        tbl[0]  = mk(0, 3'b000, '0, '0, 3'b000, 0, 0, 0, 0);
        tbl[1]  = mk(0, 3'b001, {10'd0, 5'd5}, {64'd0, 32'h1234}, 3'b001, 0, 0, 0, 0);
        tbl[2]  = mk(0, 3'b000, '0, '0, 3'b000, 0, 1, 5, 32'h1234);
        tbl[3]  = mk(0, 3'b000, '0, '0, 3'b000, 0, 0, 5, 32'h1234);
        tbl[4]  = mk(0, 3'b111, A_ALL, D_ALL, 3'b010, 0, 0, 5, 32'h1234);
        tbl[5]  = mk(0, 3'b111, A_ALL, D_ALL, 3'b100, 0, 1, 2, 32'hB);
        tbl[6]  = mk(0, 3'b111, A_ALL, D_ALL, 3'b001, 0, 1, 3, 32'hC);
        tbl[7]  = mk(0, 3'b111, A_ALL, D_ALL, 3'b010, 0, 1, 1, 32'hA);
        tbl[8]  = mk(0, 3'b000, '0, '0, 3'b000, 0, 1, 2, 32'hB);
        tbl[9]  = mk(0, 3'b010, '0, {32'h0, 32'hDEAD, 32'h0}, 3'b010, 0, 0, 2, 32'hB);
        tbl[10] = mk(0, 3'b000, '0, '0, 3'b000, 0, 0, 0, 32'hDEAD);
        tbl[11] = mk(1, 3'b100, A_STL, D_STL, 3'b000, 1, 0, 0, 32'hDEAD);
        tbl[12] = mk(1, 3'b100, A_STL, D_STL, 3'b000, 1, 0, 0, 32'hDEAD);
        tbl[13] = mk(1, 3'b100, A_STL, D_STL, 3'b000, 1, 0, 0, 32'hDEAD);
        tbl[14] = mk(0, 3'b100, A_STL, D_STL, 3'b100, 0, 0, 0, 32'hDEAD);
        tbl[15] = mk(0, 3'b000, '0, '0, 3'b000, 0, 1, 3, 32'hC);
        tbl[16] = mk(0, 3'b001, {10'd0, 5'd1}, {64'd0, 32'hA}, 3'b001, 0, 0, 3, 32'hC);
        tbl[17] = mk(1, 3'b000, '0, '0, 3'b000, 0, 1, 1, 32'hA);
        tbl[18] = mk(0, 3'b000, '0, '0, 3'b000, 0, 0, 1, 32'hA);
        tbl[19] = mk(0, 3'b101, A_PAIR, D_PAIR, 3'b100, 0, 0, 1, 32'hA);
        tbl[20] = mk(0, 3'b101, A_PAIR, D_PAIR, 3'b001, 0, 1, 9, 32'h99);
        tbl[21] = mk(0, 3'b000, '0, '0, 3'b000, 0, 1, 7, 32'h77);

        rst = 1'b1; I_stall = 1'b0; I_req_valid = 3'b001;
        I_req_waddr = {10'd0, 5'd5}; I_req_wdata = {64'd0, 32'h55};
        #3;
        chk("reset ready",  32'(O_req_ready), 32'd0);
        chk("reset we",     32'(O_rd_we), 32'd0);
        chk("reset waddr",  32'(O_rd_waddr), 32'd0);
        chk("reset wdata",  O_rd_wdata, 32'd0);
        chk("reset cnt",    O_conflict_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0; I_req_valid = 3'b000; I_req_waddr = '0; I_req_wdata = '0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            I_stall     = tbl[i].stall;
            I_req_valid = tbl[i].valid;
            I_req_waddr = tbl[i].waddr;
            I_req_wdata = tbl[i].wdata;
            #1;
            chk($sformatf("v%0d ready", i), 32'(O_req_ready), 32'(tbl[i].ready));
            chk($sformatf("v%0d busy", i),  32'(O_busy), 32'(tbl[i].busy));
            chk($sformatf("v%0d we", i),    32'(O_rd_we), 32'(tbl[i].we));
            chk($sformatf("v%0d waddr", i), 32'(O_rd_waddr), 32'(tbl[i].oaddr));
            chk($sformatf("v%0d wdata", i), O_rd_wdata, tbl[i].odata);
        end
`ifdef WB_ARB_STAT_EN
        exp_cnt = 6;
`else
        exp_cnt = 0;
`endif
        chk("table conflict cnt", O_conflict_cnt, 32'(exp_cnt));

        // Async reset discards a registered write and returns the pointer to 0.
        @(negedge clk);
        I_stall = 1'b0; I_req_valid = 3'b010;
        I_req_waddr = {5'd0, 5'd4, 5'd0}; I_req_wdata = {32'h0, 32'h44, 32'h0};
        #1;
        chk("rst seq grant", 32'(O_req_ready), 32'b010);
        @(posedge clk);
        #1;
        chk("rst seq we before", 32'(O_rd_we), 32'd1);
        chk("rst seq addr before", 32'(O_rd_waddr), 32'd4);
        #1 rst = 1'b1;
        #1;
        chk("rst seq we after", 32'(O_rd_we), 32'd0);
        chk("rst seq ready in rst", 32'(O_req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0; I_req_valid = 3'b110;
        I_req_waddr = {5'd6, 5'd4, 5'd0}; I_req_wdata = {32'h66, 32'h44, 32'h0};
        #1;
        chk("rst seq ptr0 grant", 32'(O_req_ready), 32'b010);

        // Contention counter: four two-way cycles, two single cycles.
        @(negedge clk);
        rst = 1'b1; I_req_valid = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            I_req_valid = (k < 4) ? 3'b011 : 3'b001;
            I_req_waddr = {5'd0, 5'd2, 5'd1}; I_req_wdata = {32'h0, 32'hB, 32'hA};
        end
        @(negedge clk);
        I_req_valid = 3'b000;
        #1;
`ifdef WB_ARB_STAT_EN
        exp_cnt = 4;
`else
        exp_cnt = 0;
`endif
        chk("stat conflict cnt", O_conflict_cnt, 32'(exp_cnt));

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the general-purpose register file's single write port between N_REQ write-back sources: ALU, load unit, mul/div/CSR.
- Uses a round-robin arbiter with a valid/ready handshake per source.
- The winning write is registered one cycle, then driven onto the register file's I_rd_we / I_rd_waddr / I_rd_wdata.
- Sits between the execute/memory stage outputs and the regfile.

Parameters:
- N_REQ, 3, number of write-back requesters; index 0 = ALU, 1 = LSU, 2 = MDU/CSR.
- ADDR_W, 5, register address width (32 GPRs).
- DATA_W, 32, register data width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- I_stall  in  1  back-pressure from the pipeline; while 1, no grants are issued.
- I_req_valid  in  N_REQ  per-requester write request.
- I_req_waddr  in  N_REQ*ADDR_W  packed destination addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- I_req_wdata  in  N_REQ*DATA_W  packed write data, same packing.
- O_req_ready  out  N_REQ  one-hot grant; transfer occurs when valid & ready.
- O_rd_we  out  1  write enable to the regfile.
- O_rd_waddr  out  ADDR_W  write address to the regfile.
- O_rd_wdata  out  DATA_W  write data to the regfile.
- O_busy  out  1  1 when any I_req_valid is set and no grant was issued this cycle.
- O_conflict_cnt  out  32  contention counter; see Optional Feature.

Behaviour:
- Reset (async, rst=1):
  - O_rd_we=0, O_rd_waddr=0, O_rd_wdata=0, O_conflict_cnt=0.
  - Round-robin pointer = 0.
  - O_req_ready=0 while rst is high.
- Grant is combinational in-cycle:
  - Search starts at pointer p and scans i = p, p+1, … (mod N_REQ).
  - The first i with I_req_valid[i]=1 gets O_req_ready[i]=1.
  - At most one ready bit is high.
  - No grant when I_stall=1 or no valid is set.
- Requester obligation: once valid rises, waddr/wdata must hold until accepted.
  - The arbiter never drops a pending request.
  - The arbiter does not require stability; it samples only on handshake.
- Pointer update: on a handshake with requester g, p <= (g+1) mod N_REQ at the posedge. Otherwise p holds.
- Starvation bound: a continuously valid requester is granted within N_REQ cycles of unstalled operation.
- Output stage, 1-cycle latency:
  - On a handshake at edge k, at edge k+1 the outputs become O_rd_we=1, O_rd_waddr=req waddr, O_rd_wdata=req wdata.
  - With no handshake, O_rd_we=0 next cycle. waddr/wdata hold their last values.
- Writes to x0:
  - Granted normally so the requester drains.
  - O_rd_we is forced to 0 for that transfer; O_rd_waddr is still updated to 0.
- Same rd from several requesters: serialized in grant order, last write wins. The arbiter does no ordering check; hazard control is the issue logic's job.
- I_stall during the cycle after a grant does not cancel the registered write. The registered write still issues.
- rst asserted mid-operation: any in-flight registered write is discarded (O_rd_we=0 immediately) and the pointer returns to 0.
- O_busy = |I_req_valid & ~|O_req_ready. It is combinational.

Optional Feature:
- Macro: WB_ARB_STAT_EN.
- Defined:
  - O_conflict_cnt increments by 1 every unstalled cycle with two or more bits of I_req_valid set.
  - It saturates at 32'hFFFF_FFFF.
  - It resets to 0 on rst.
  - A DPI-C call wb_arb_stat(cnt) is made when an ebreak-halt is signalled elsewhere. That call is not in this block's scope beyond the counter value.
- Undefined: O_conflict_cnt is tied to 0 and the counter logic is absent.

Decomposition:
- Shared defines/package holds:
  - RegAddrBus/RegDataBus widths (ADDR_W, DATA_W).
  - ZeroReg (5'd0) and ZeroWord.
  - WB_REQ_ALU=0, WB_REQ_LSU=1, WB_REQ_MDU=2.
  - WB_REQ_NUM=3.
- One sub-module, rr_arbiter:
  - Contents: pointer register, rotate/priority-encode grant, pointer update.
  - Parameter N. Inputs: req, en, accept. Outputs: one-hot grant, grant index.
- rf_wb_arbiter instantiates rr_arbiter and adds the data mux, output register, x0 squash and stats.

Test Plan:
- Single request: valid[0]=1, waddr=5, wdata=32'h1234 at cycle 1 → ready[0]=1 in cycle 1; cycle 2 O_rd_we=1, waddr=5, wdata=32'h1234; cycle 3 O_rd_we=0.
- All three held valid (waddr 1/2/3, wdata 0xA/0xB/0xC) from reset → grants 0,1,2,0,… on consecutive cycles; outputs show addrs 1,2,3,1 one cycle later; no gap cycles.
- x0 write: valid[1]=1, waddr=0, wdata=32'hDEAD → ready[1]=1; next cycle O_rd_we=0, O_rd_waddr=0.
- Stall: valid[2]=1 with I_stall=1 for 3 cycles → ready=0, O_busy=1 for all 3; stall drops → grant in that cycle, write one cycle later.
- Async reset mid-flight: grant at edge k, rst pulsed between edges → O_rd_we=0 immediately; after release, valid[1]=valid[2]=1 → requester 1 granted first (pointer=0).
- With WB_ARB_STAT_EN: 4 cycles with valid=3'b011 plus 2 cycles with valid=3'b001 → O_conflict_cnt=4. Without the macro → O_conflict_cnt stays 0.
